// File: rtl/whackamole_pkg.sv
// Shared types and constants for the whack-a-mole game engine.
// State encoding, LFSR tap mask and default seed.
package whackamole_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  // Feedback taps 16,14,13,11 mapped onto bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used for mole selection.
// Shifts left every clock; reloads the seed on reset.
module mole_lfsr
  import whackamole_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] rnd
);

  logic feedback;

  assign feedback = ^(rnd & LFSR_TAPS);

  // Advance one step per clock in every game state
  always_ff @(posedge clock) begin
    if (!reset) rnd <= seed;
    else        rnd <= {rnd[14:0], feedback};
  end

endmodule

// File: rtl/whackamole_core.sv
// Whack-a-mole engine: FSM, mole spawn/age, round timer, score, misses.
// Define WHACKAMOLE_PENALTY_EN to make wrong presses also cost a point.
module whackamole_core
  import whackamole_pkg::*;
#(
  parameter int          NUM_MOLES   = 5,
  parameter int          ROUND_TICKS = 30,
  parameter int          MOLE_TICKS  = 2,
  parameter int          SCORE_W     = 8,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_SEED
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               tick,
  input  logic                               start,
  input  logic [NUM_MOLES-1:0]               hit_btn,
  output logic [NUM_MOLES-1:0]               mole_led,
  output logic [SCORE_W-1:0]                 score,
  output logic [SCORE_W-1:0]                 misses,
  output logic [$clog2(ROUND_TICKS+1)-1:0]   time_left,
  output logic                               playing,
  output logic                               game_over
);

  localparam int TW = $clog2(ROUND_TICKS+1);
  localparam int IW = $clog2(NUM_MOLES);
  localparam int AW = $clog2(MOLE_TICKS+1);
  localparam logic [SCORE_W-1:0] SAT = '1;

  state_t state;
  state_t nextState;

  logic [15:0]          rnd;
  logic [7:0]           rawIdx;
  logic [IW-1:0]        moleIdx;
  logic [IW-1:0]        pickIdx;
  logic [NUM_MOLES-1:0] pickLed;
  logic [AW-1:0]        age;

  logic inPlay;
  logic doStart;
  logic hitOk;
  logic wrongPress;
  logic tickPlay;
  logic lastTick;
  logic escape;
  logic spawn;

  logic [1:0]         missInc;
  logic [SCORE_W:0]   missSum;
  logic [SCORE_W-1:0] missNext;

  mole_lfsr uLfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .rnd   (rnd)
  );

  assign inPlay     = (state == PLAY);
  assign doStart    = start && !inPlay;
  assign hitOk      = inPlay && (|(hit_btn & mole_led));
  assign wrongPress = inPlay && (|hit_btn) && !hitOk;
  assign tickPlay   = inPlay && tick;
  assign lastTick   = tickPlay && (time_left == TW'(1));
  assign escape     = tickPlay && !hitOk
                    && (age == AW'(MOLE_TICKS-1));
  assign spawn      = doStart
                    || (inPlay && !lastTick && (hitOk || escape));

  assign rawIdx  = rnd[7:0] % 8'(NUM_MOLES);
  assign pickLed = NUM_MOLES'(1) << pickIdx;

  // Pick a new mole, stepping past the previous one on a repeat
  always_comb begin
    pickIdx = IW'(rawIdx);
    if (IW'(rawIdx) == moleIdx) begin
      if (moleIdx == IW'(NUM_MOLES-1)) pickIdx = '0;
      else                             pickIdx = moleIdx + IW'(1);
    end
  end

  // Escape and wrong press in one cycle each cost one miss
  always_comb begin
    missInc  = {1'b0, escape} + {1'b0, wrongPress};
    missSum  = {1'b0, misses} + (SCORE_W+1)'(missInc);
    missNext = (missSum > {1'b0, SAT}) ? SAT : missSum[SCORE_W-1:0];
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (start)    nextState = PLAY;
      PLAY:    if (lastTick) nextState = OVER;
      OVER:    if (start)    nextState = PLAY;
      default:               nextState = IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    playing   = (state == PLAY);
    game_over = (state == OVER);
  end

  // Round timer
  always_ff @(posedge clock) begin
    if (!reset)        time_left <= TW'(ROUND_TICKS);
    else if (doStart)  time_left <= TW'(ROUND_TICKS);
    else if (tickPlay) time_left <= time_left - TW'(1);
  end

  // Active mole and its age; a hit or escape respawns at age 0
  always_ff @(posedge clock) begin
    if (!reset) begin
      mole_led <= '0;
      moleIdx  <= '0;
      age      <= '0;
    end else if (spawn) begin
      mole_led <= pickLed;
      moleIdx  <= pickIdx;
      age      <= '0;
    end else if (lastTick) begin
      mole_led <= '0;
    end else if (tickPlay) begin
      age      <= age + AW'(1);
    end
  end

  // Score, saturating at both ends
  always_ff @(posedge clock) begin
    if (!reset) begin
      score <= '0;
    end else if (doStart) begin
      score <= '0;
    end else if (hitOk) begin
      if (score != SAT) score <= score + SCORE_W'(1);
`ifdef WHACKAMOLE_PENALTY_EN
    end else if (wrongPress) begin
      if (score != '0) score <= score - SCORE_W'(1);
`endif
    end
  end

  // Miss counter
  always_ff @(posedge clock) begin
    if (!reset)       misses <= '0;
    else if (doStart) misses <= '0;
    else              misses <= missNext;
  end

endmodule

// File: tb/tb_whackamole_core.sv
// Directed bench for whackamole_core (5 moles, 5-tick round).
// Mole positions are predicted from a reference LFSR.
module tb_whackamole_core;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick  = 1'b0;
  logic       start = 1'b0;
  logic [4:0] hit_btn = '0;
  logic [4:0] mole_led;
  logic [1:0] score;
  logic [1:0] misses;
  logic [2:0] time_left;
  logic       playing;
  logic       game_over;

  int tests = 0;
  int fails = 0;
  int eIdx  = 0;
  logic [4:0]  eLed = '0;
  logic [15:0] mLfsr;

  whackamole_core #(
    .NUM_MOLES   (5),
    .ROUND_TICKS (5),
    .MOLE_TICKS  (2),
    .SCORE_W     (2),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .hit_btn   (hit_btn),
    .mole_led  (mole_led),
    .score     (score),
    .misses    (misses),
    .time_left (time_left),
    .playing   (playing),
    .game_over (game_over)
  );

  always #5 clock = ~clock;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting left
  always @(posedge clock) begin
    if (!reset) mLfsr <= 16'hACE1;
    else mLfsr <= {mLfsr[14:0],
                   mLfsr[15] ^ mLfsr[13] ^ mLfsr[12] ^ mLfsr[10]};
  end

  function automatic int nextIdx(input logic [15:0] r,
                                 input int prev);
    int i;
    i = int'(r[7:0]) % 5;
    if (i == prev) i = (i == 4) ? 0 : i + 1;
    return i;
  endfunction

  function automatic logic [4:0] other(input logic [4:0] led);
    return {led[3:0], led[4]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; sp/clr say what the mole should do
  task automatic cyc(input logic t, input logic s,
                     input logic [4:0] b,
                     input logic sp, input logic clr);
    int p;
    tick = t;
    start = s;
    hit_btn = b;
    p = nextIdx(mLfsr, eIdx);
    @(posedge clock);
    #1;
    tick = 1'b0;
    start = 1'b0;
    hit_btn = '0;
    if (sp) begin
      eIdx = p;
      eLed = 5'd1 << p;
    end else if (clr) begin
      eLed = '0;
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    chk("rst_led", 32'(mole_led), 32'h0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_miss", 32'(misses), 32'd0);
    chk("rst_time", 32'(time_left), 32'd5);
    chk("rst_play", 32'(playing), 32'd0);
    chk("rst_over", 32'(game_over), 32'd0);

    cyc(1'b0, 1'b0, 5'h01, 1'b0, 1'b0);
    chk("idle_hit_score", 32'(score), 32'd0);
    chk("idle_hit_miss", 32'(misses), 32'd0);
    chk("idle_hit_led", 32'(mole_led), 32'h0);

    cyc(1'b0, 1'b1, 5'h00, 1'b1, 1'b0);
    chk("start_play", 32'(playing), 32'd1);
    chk("start_time", 32'(time_left), 32'd5);
    chk("start_led", 32'(mole_led), 32'(eLed));

    cyc(1'b0, 1'b0, other(eLed), 1'b0, 1'b0);
    chk("wrong_miss", 32'(misses), 32'd1);
    chk("wrong_score", 32'(score), 32'd0);
    chk("wrong_led", 32'(mole_led), 32'(eLed));

    cyc(1'b0, 1'b0, eLed | other(eLed), 1'b1, 1'b0);
    chk("combo_score", 32'(score), 32'd1);
    chk("combo_miss", 32'(misses), 32'd1);
    chk("combo_led", 32'(mole_led), 32'(eLed));

    cyc(1'b1, 1'b0, 5'h00, 1'b0, 1'b0);
    chk("t1_time", 32'(time_left), 32'd4);
    chk("t1_miss", 32'(misses), 32'd1);
    cyc(1'b1, 1'b0, 5'h00, 1'b1, 1'b0);
    chk("t2_time", 32'(time_left), 32'd3);
    chk("t2_miss", 32'(misses), 32'd2);
    chk("t2_led", 32'(mole_led), 32'(eLed));
    cyc(1'b1, 1'b0, 5'h00, 1'b0, 1'b0);
    chk("t3_miss", 32'(misses), 32'd2);
    cyc(1'b1, 1'b0, 5'h00, 1'b1, 1'b0);
    chk("t4_time", 32'(time_left), 32'd1);
    chk("t4_miss", 32'(misses), 32'd3);
    chk("t4_led", 32'(mole_led), 32'(eLed));

    cyc(1'b1, 1'b0, eLed, 1'b0, 1'b1);
    chk("last_score", 32'(score), 32'd2);
    chk("last_time", 32'(time_left), 32'd0);
    chk("last_over", 32'(game_over), 32'd1);
    chk("last_play", 32'(playing), 32'd0);
    chk("last_led", 32'(mole_led), 32'h0);

    cyc(1'b1, 1'b0, 5'h1f, 1'b0, 1'b0);
    chk("over_score", 32'(score), 32'd2);
    chk("over_miss", 32'(misses), 32'd3);
    chk("over_time", 32'(time_left), 32'd0);

    cyc(1'b0, 1'b1, 5'h00, 1'b1, 1'b0);
    chk("re_score", 32'(score), 32'd0);
    chk("re_miss", 32'(misses), 32'd0);
    chk("re_time", 32'(time_left), 32'd5);
    chk("re_over", 32'(game_over), 32'd0);
    chk("re_led", 32'(mole_led), 32'(eLed));

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, eLed, 1'b1, 1'b0);
      chk("sat_led", 32'(mole_led), 32'(eLed));
      chk("sat_score", 32'(score), (i < 3) ? 32'(i + 1) : 32'd3);
    end

    cyc(1'b1, 1'b0, eLed, 1'b1, 1'b0);
    chk("hittick_time", 32'(time_left), 32'd4);
    chk("hittick_led", 32'(mole_led), 32'(eLed));
    cyc(1'b1, 1'b0, 5'h00, 1'b0, 1'b0);
    chk("age0_miss", 32'(misses), 32'd0);
    cyc(1'b1, 1'b0, 5'h00, 1'b1, 1'b0);
    chk("age1_miss", 32'(misses), 32'd1);
    chk("age1_led", 32'(mole_led), 32'(eLed));

    cyc(1'b0, 1'b1, 5'h00, 1'b0, 1'b0);
    chk("playstart_time", 32'(time_left), 32'd2);
    chk("playstart_score", 32'(score), 32'd3);

    cyc(1'b0, 1'b0, other(eLed), 1'b0, 1'b0);
    chk("wrong2_miss", 32'(misses), 32'd2);
`ifdef WHACKAMOLE_PENALTY_EN
    chk("wrong2_score", 32'(score), 32'd2);
`else
    chk("wrong2_score", 32'(score), 32'd3);
`endif

    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    eIdx = 0;
    eLed = '0;
    chk("mid_led", 32'(mole_led), 32'h0);
    chk("mid_score", 32'(score), 32'd0);
    chk("mid_miss", 32'(misses), 32'd0);
    chk("mid_time", 32'(time_left), 32'd5);
    chk("mid_play", 32'(playing), 32'd0);

    cyc(1'b0, 1'b1, 5'h00, 1'b1, 1'b0);
    chk("post_led", 32'(mole_led), 32'(eLed));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/whackamole_core.md
# whackamole_core

Parametrised game engine for the whack-a-mole design: owns the game state machine, random mole selection, per-mole lifetime, round timer, score and miss counting. Sits between the debounced start/mole-button pulses and the clock-divider tick on the input side, and the mole LEDs and score/timer display logic on the output side. Replaces the fixed five-mole, always-on enable scheme with a complete timed round that can be restarted.

## Interface
- NUM_MOLES, 5: number of moles/buttons/LEDs; 2..16.
- ROUND_TICKS, 30: round length in `tick` pulses; ≥ 1.
- MOLE_TICKS, 2: ticks a mole stays up before it escapes; ≥ 1.
- SCORE_W, 8: width of `score` and `misses`.
- LFSR_SEED, 16'hACE1: non-zero reset value of the selection LFSR.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  single-cycle enable pulse from the clock divider, 1 Hz.
- start  in  1  debounced single-cycle start pulse.
- hit_btn  in  NUM_MOLES  debounced single-cycle mole-button pulses.
- mole_led  out  NUM_MOLES  one-hot active mole; all zero when no mole is up.
- score  out  SCORE_W  moles hit this round.
- misses  out  SCORE_W  escaped moles plus wrong-button presses.
- time_left  out  clog2(ROUND_TICKS+1)  remaining ticks.
- playing  out  1  high in PLAY.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, PLAY, OVER.
- Reset: state IDLE; mole_led 0; score 0; misses 0; time_left ROUND_TICKS; playing 0; game_over 0; LFSR at LFSR_SEED.
- IDLE: on `start`, clear score and misses, load time_left = ROUND_TICKS, spawn a mole, and go to PLAY.
- PLAY, on each tick: time_left decrements; the active mole's age counter increments.
  - When the age reaches MOLE_TICKS, the mole escapes: misses +1 and a new mole spawns in the same cycle.
  - When time_left reaches 0, go to OVER and clear mole_led.
- Hit: hit_btn & mole_led ≠ 0 → score +1, then spawn a new mole with age 0.
- Wrong press: hit_btn ≠ 0 with no bit matching the active mole → misses +1, counted once per cycle regardless of how many bits are set.
  - A cycle that contains the correct bit counts as a hit only.
- Spawn: index = LFSR[7:0] mod NUM_MOLES. If the index equals the previous mole, use index+1 wrapping to 0.
  - The LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every clock in all states.
- Counters saturate at 2^SCORE_W−1 and never wrap.
- OVER: outputs hold their final score and misses. `start` restarts the round exactly as from IDLE.
- `start` in PLAY is ignored. `hit_btn` in IDLE or OVER is ignored.

## Timing
- All outputs are registered.
- Latencies, from the input pulse at cycle T:
  - Input-to-output updates (hit/miss/score, tick effects on the mole and timer, `start` to PLAY) land at T+1.
  - Round length from `start` is ROUND_TICKS tick pulses exactly. The last tick's time_left = 0 and OVER both appear at T+1.
- Simultaneous events:
  - Hit and tick in the same cycle: the hit wins. The new mole's age starts at 0 and the tick does not age it. time_left still decrements.
  - Hit and escape in the same cycle: counts as a hit, not a miss.
  - Hit on the final tick: the hit is counted and the state goes to OVER.
- Reset mid-round: all outputs return to reset values on the next edge.

## Configuration
- WHACKAMOLE_PENALTY_EN defined: a wrong press also decrements score, saturating at 0, in addition to misses +1.
- WHACKAMOLE_PENALTY_EN undefined: a wrong press affects only misses. The score never decreases.

## Structure
- Package whackamole_pkg holds the state enum (IDLE, PLAY, OVER), STATE_W, the LFSR tap constant, and the default LFSR seed.
- Sub-module mole_lfsr, with ports clock, reset, seed, and rnd[15:0]. It is instantiated once and free-runs.
- The FSM, age/timer counters and score logic stay in whackamole_core.

## Test plan
- Reset, then start; hit the lit mole within the first tick; repeat 3 times → score = 3, misses = 0, and mole_led is one-hot and never repeats the same index back-to-back.
- Start with MOLE_TICKS = 2 and press nothing for 4 ticks → misses = 2, score = 0, two distinct spawns.
- Press a non-lit button once, then press lit and non-lit buttons together → misses = 1, score = 1; with WHACKAMOLE_PENALTY_EN, score = 0 after the first press, then 1.
- ROUND_TICKS = 5: count ticks after start → on tick 5, time_left = 0, game_over = 1, mole_led = 0; `start` then gives score = 0 and time_left = 5.
- Hit coincident with the final tick → the score increments and OVER is entered in the same cycle.
- SCORE_W = 2, 5 hits → score saturates at 3. Assert reset mid-round → all reset values on the next edge.
